// File: rtl/wave_capture_pkg.sv
//------------------------------------------------------------------------------
// Module : wave_capture_pkg
// Brief  : Shared types and default widths for the waveform capture writer.
//          cap_state_t is the capture FSM state. DEFAULT_* are the default
//          parameter values for the writer and its trigger detector.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package wave_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH    = 8;

endpackage

`default_nettype wire

// File: rtl/wave_trig_detect.sv
//------------------------------------------------------------------------------
// Module : wave_trig_detect
// Brief  : Detects a rising crossing of trig_level by the accepted sample
//          stream. The detector remembers the previously accepted sample, and
//          trig fires when that sample was below the level and the current
//          sample is at or above it (unsigned compare).
// Ports  : clk, rst         clock and synchronous active-high reset
//          clear            forget the previous sample (new arming)
//          accept           current in_data is being consumed
//          in_data          current sample
//          trig_level       threshold
//          trig             combinational trigger for the current sample
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wave_trig_detect
  import wave_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] trig_level,
  output logic                  trig
);

  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (clear) begin
      prev_vld <= 1'b0;
    end else if (accept) begin
      prev     <= in_data;
      prev_vld <= 1'b1;
    end
  end

  // No history after arming means no crossing can be seen yet.
  assign trig = prev_vld && (prev < trig_level) && (in_data >= trig_level);

endmodule

`default_nettype wire

// File: rtl/wave_capture_writer.sv
//------------------------------------------------------------------------------
// Module : wave_capture_writer
// Brief  : Captures a triggered window of DEPTH = 2**ADDRESS_WIDTH samples
//          from a valid/ready stream into the write port of a dual-port RAM.
// Ports  : clk, rst         clock and synchronous active-high reset
//          arm, abort       one-cycle control pulses (abort has priority)
//          trig_level       rising-edge trigger threshold
//          in_valid/in_data/in_ready   sample stream
//          wr_en/wr_addr/wr_data       RAM write port, one cycle after accept
//          count            samples written in the current/last capture
//          armed/busy/done  state indicators
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wave_capture_writer
  import wave_capture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     armed,
  output logic                     busy,
  output logic                     done
);

  cap_state_t state;
  logic       accept;
  logic       start;
  logic       trig;
  logic       do_write;

  assign in_ready = (state == ARMED) || (state == CAPTURE);
  assign accept   = in_valid && in_ready;

  // Arming is only honoured from IDLE or DONE; abort overrides it.
  assign start = arm && !abort && ((state == IDLE) || (state == DONE));

  // An accept in the abort cycle is dropped: the capture is being cancelled.
  assign do_write = accept && !abort &&
                    ((state == CAPTURE) || ((state == ARMED) && trig));

  wave_trig_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_trig (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .accept     (accept && (state == ARMED)),
    .in_data    (in_data),
    .trig_level (trig_level),
    .trig       (trig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= count[ADDRESS_WIDTH-1:0];
        wr_data <= in_data;
        count   <= count + 1'b1;
      end

      if (abort) begin
        state <= IDLE;
      end else if (start) begin
        state <= ARMED;
        count <= '0;
      end else if (do_write) begin
        // While writing, count < DEPTH, so all-ones low bits mean this is
        // the DEPTH-th write and the capture is complete.
        state <= (&count[ADDRESS_WIDTH-1:0]) ? DONE : CAPTURE;
      end
    end
  end

  assign armed = (state == ARMED);
  assign busy  = (state == CAPTURE);
  assign done  = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_wave_capture_writer.sv
`default_nettype none

module tb_wave_capture_writer;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] trig_level = 8'h80;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   count;
  logic          armed;
  logic          busy;
  logic          done;

  wave_capture_writer #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .trig_level (trig_level),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .count      (count),
    .armed      (armed),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 capturing, 3 full.
  // hist holds every sample accepted since arming; the trigger is judged
  // from its last entry and the new sample.
  int m_mode = 0;
  int m_count = 0;
  bit m_wr_en = 0;
  int m_wr_addr = 0;
  int m_wr_data = 0;
  int hist[$];

  function automatic logic [3:0] m_flags();
    return {(m_mode == 1 || m_mode == 2), (m_mode == 1), (m_mode == 2), (m_mode == 3)};
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
  task automatic tick(input bit r, input bit a, input bit ab, input bit v, input int d);
    bit ready;
    bit hit;
    rst = r; arm = a; abort = ab; in_valid = v; in_data = d[7:0];
    ready   = (m_mode == 1 || m_mode == 2);
    m_wr_en = 0;
    if (r) begin
      m_mode = 0; m_count = 0; m_wr_addr = 0; m_wr_data = 0; hist.delete();
    end else if (ab) begin
      m_mode = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (a) begin m_mode = 1; m_count = 0; hist.delete(); end
    end else if (v && ready) begin
      hit = (m_mode == 2) ||
            (hist.size() > 0 && hist[hist.size()-1] < int'(trig_level) && d >= int'(trig_level));
      if (m_mode == 1) hist.push_back(d);
      if (hit) begin
        m_wr_en = 1; m_wr_addr = m_count; m_wr_data = d;
        m_count++;
        m_mode = (m_count == DEPTH) ? 3 : 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 8'h55);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, $urandom_range(0, 255));
      n_checks++;
      if ({in_ready, wr_en, armed, busy, done} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {in_ready, wr_en, armed, busy, done});
      else n_pass++;
      n_checks++;
      if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count);
      else n_pass++;
      n_checks++;
      if ({wr_addr, wr_data} !== 12'h000) $display("FAIL reset_wport: got addr %0d data %h want 0/00", wr_addr, wr_data);
      else n_pass++;
    end
  endtask

  task automatic test_trigger_basic();
    trig_level = 8'h80;
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if ({in_ready, armed} !== 2'b11) $display("FAIL arm_state: got ready %b armed %b want 1 1", in_ready, armed);
    else n_pass++;
    tick(0, 0, 0, 1, 8'h10);
    tick(0, 0, 0, 1, 8'h70);
    n_checks++;
    if (wr_en !== 1'b0) $display("FAIL pre_trig_write: got wr_en %b want 0", wr_en);
    else n_pass++;
    tick(0, 0, 0, 1, 8'h90);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'd0, 8'h90, 1'b1})
      $display("FAIL trig_write: got en %b addr %0d data %h busy %b want 1 0 90 1", wr_en, wr_addr, wr_data, busy);
    else n_pass++;
    tick(0, 0, 0, 1, 8'h91);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 4'd1, 8'h91, 5'd2})
      $display("FAIL second_write: got en %b addr %0d data %h count %0d want 1 1 91 2", wr_en, wr_addr, wr_data, count);
    else n_pass++;
  endtask

  task automatic test_full_capture();
    int next_addr = 2;
    int budget = 0;
    while (!done && budget < 30) begin
      tick(0, 0, 0, 1, $urandom_range(0, 255));
      budget++;
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, next_addr[3:0], m_wr_data[7:0]})
        $display("FAIL full_seq: got en %b addr %0d data %h want 1 %0d %h", wr_en, wr_addr, wr_data, next_addr, m_wr_data);
      else n_pass++;
      next_addr++;
    end
    n_checks++;
    if ({done, in_ready, count, next_addr[4:0]} !== {1'b1, 1'b0, 5'd16, 5'd16})
      $display("FAIL full_end: got done %b ready %b count %0d writes %0d want 1 0 16 16", done, in_ready, count, next_addr);
    else n_pass++;
    tick(0, 0, 0, 1, 8'hA5);
    n_checks++;
    if ({wr_en, count, done} !== {1'b0, 5'd16, 1'b1})
      $display("FAIL extra_sample: got en %b count %0d done %b want 0 16 1", wr_en, count, done);
    else n_pass++;
  endtask

  task automatic test_first_sample();
    trig_level = 8'h80;
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if ({count, done, armed} !== {5'd0, 1'b0, 1'b1}) $display("FAIL rearm_done: got count %0d done %b armed %b want 0 0 1", count, done, armed);
    else n_pass++;
    tick(0, 0, 0, 1, 8'hFF);
    tick(0, 0, 0, 1, 8'h00);
    n_checks++;
    if ({wr_en, armed} !== 2'b01) $display("FAIL first_no_trig: got en %b armed %b want 0 1", wr_en, armed);
    else n_pass++;
    tick(0, 0, 0, 1, 8'h80);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'd0, 8'h80, 1'b1})
      $display("FAIL boundary_trig: got en %b addr %0d data %h busy %b want 1 0 80 1", wr_en, wr_addr, wr_data, busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    int writes = 1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1, $urandom_range(0, 255));
      if (wr_en) writes++;
    end
    n_checks++;
    if ({wr_en, wr_addr, count} !== {1'b1, 4'd4, 5'd5}) $display("FAIL pre_abort: got en %b addr %0d count %0d want 1 4 5", wr_en, wr_addr, count);
    else n_pass++;
    tick(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (wr_en) writes++;
      tick(0, 0, 0, 1, $urandom_range(0, 255));
    end
    n_checks++;
    if ({in_ready, armed, busy, done, count} !== {4'b0000, 5'd5})
      $display("FAIL abort_state: got flags %b count %0d want 0000 5", {in_ready, armed, busy, done}, count);
    else n_pass++;
    n_checks++;
    if (writes != 5) $display("FAIL abort_writes: got %0d want 5", writes);
    else n_pass++;
  endtask

  task automatic test_gaps_rearm();
    int next_addr = 0;
    int cyc = 0;
    trig_level = 8'h80;
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 8'h00);
    while (!done && cyc < 80) begin
      tick(0, 0, 0, (cyc % 2) == 0, (cyc == 0) ? 8'hC0 : $urandom_range(0, 255));
      if (wr_en) begin
        n_checks++;
        if ({wr_addr, wr_data} !== {next_addr[3:0], m_wr_data[7:0]})
          $display("FAIL gap_seq: got addr %0d data %h want %0d %h", wr_addr, wr_data, next_addr, m_wr_data);
        else n_pass++;
        next_addr++;
      end
      cyc++;
    end
    n_checks++;
    if ({done, count, next_addr[4:0]} !== {1'b1, 5'd16, 5'd16})
      $display("FAIL gap_end: got done %b count %0d writes %0d want 1 16 16", done, count, next_addr);
    else n_pass++;
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if ({count, armed, done} !== {5'd0, 1'b1, 1'b0}) $display("FAIL gap_rearm: got count %0d armed %b done %b want 0 1 0", count, armed, done);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    tick(0, 0, 0, 1, 8'h00);
    tick(0, 0, 0, 1, 8'hF0);
    tick(0, 0, 0, 1, 8'h11);
    tick(1, 0, 0, 1, 8'h22);
    n_checks++;
    if ({wr_en, in_ready, armed, busy, done, count, wr_addr, wr_data} !== 22'd0)
      $display("FAIL rst_mid: got en %b flags %b count %0d addr %0d data %h want all 0",
               wr_en, {in_ready, armed, busy, done}, count, wr_addr, wr_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) trig_level = 8'($urandom_range(0, 255));
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 255));
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {m_wr_en, m_wr_addr[3:0], m_wr_data[7:0]})
        $display("FAIL rand_wport @%0d: got en %b addr %0d data %h want %b %0d %h",
                 i, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
      else n_pass++;
      n_checks++;
      if ({in_ready, armed, busy, done, count} !== {m_flags(), m_count[4:0]})
        $display("FAIL rand_state @%0d: got flags %b count %0d want %b %0d",
                 i, {in_ready, armed, busy, done}, count, m_flags(), m_count);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_trigger_basic();
    test_full_capture();
    test_first_sample();
    test_abort();
    test_gaps_rearm();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
